// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two
// requesters. One operation in flight: operands are registered and held on
// the ALU for EXEC_CYCLES cycles, then result and flags are registered and
// returned on the granted requester's response channel.
module alu_arbiter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CTR_W       = 3,
  parameter int          EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CTR_W-1:0] req0_ctr,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic [2:0]       rsp0_flags,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CTR_W-1:0] req1_ctr,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic [2:0]       rsp1_flags,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTR_W-1:0] alu_ctr,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_co,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             busy
);

  // Values below 1 behave as a single execute cycle.
  localparam int unsigned ExecN = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int unsigned CntW  = (ExecN > 1) ? $clog2(ExecN) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             grant_q;
  logic             last_grant_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CTR_W-1:0] ctr_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       flags_q;
  logic [1:0]       rsp_valid_q;

  logic winner;
  logic idle;
  logic accept;
  logic rsp_done;

  // Pick the winner: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_q;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  // Ready is masked by reset so nothing is offered while the block is held in reset.
  assign idle       = (state_q == StIdle) & rst_n;
  assign req0_ready = idle & req0_valid & ~winner;
  assign req1_ready = idle & req1_valid & winner;
  assign accept     = req0_ready | req1_ready;
  // Only the granted requester's ready can release the response.
  assign rsp_done   = grant_q ? rsp1_ready : rsp0_ready;

  // Main FSM: accept in IDLE, hold operands in EXEC, present result in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ctr_q        <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      rsp_valid_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            a_q          <= winner ? req1_a : req0_a;
            b_q          <= winner ? req1_b : req0_b;
            ctr_q        <= winner ? req1_ctr : req0_ctr;
            grant_q      <= winner;
            last_grant_q <= winner;
            cnt_q        <= CntW'(ExecN - 1);
            state_q      <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            res_q       <= alu_res;
            flags_q     <= {alu_ovf, alu_zero, alu_co};
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (rsp_done) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ALU is fed only from the operand registers, so it is stable through EXEC.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_ctr = ctr_q;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_res   = res_q;
  assign rsp1_res   = res_q;
  assign rsp0_flags = flags_q;
  assign rsp1_flags = flags_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1 and one with
// EXEC_CYCLES=4, each driving a small behavioural ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {ovf, zero, co, res}: add for ctr==2, AND otherwise.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] ctr);
    logic [32:0] s;
    logic [31:0] r;
    logic        ovf;
    logic        co;
    if (ctr == 3'd2) begin
      s   = {1'b0, a} + {1'b0, b};
      r   = s[31:0];
      co  = s[32];
      ovf = (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r   = a & b;
      co  = 1'b0;
      ovf = 1'b0;
    end
    return {ovf, (r == 32'd0), co, r};
  endfunction

  // ---------------- instance with EXEC_CYCLES = 1 ----------------
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctr, req1_ctr;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_res, rsp1_res;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_ctr;
  logic        alu_co, alu_zero, alu_ovf, busy;

  assign {alu_ovf, alu_zero, alu_co, alu_res} = alu_model(alu_a, alu_b, alu_ctr);

  alu_arbiter #(.WIDTH(32), .CTR_W(3), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctr(req0_ctr), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_res(rsp0_res), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctr(req1_ctr), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_res(rsp1_res), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_res(alu_res),
    .alu_co(alu_co), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .busy(busy)
  );

  // ---------------- instance with EXEC_CYCLES = 4 ----------------
  logic        x_req0_valid, x_req0_ready, x_req1_valid, x_req1_ready;
  logic [31:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b;
  logic [2:0]  x_req0_ctr, x_req1_ctr;
  logic        x_rsp0_valid, x_rsp0_ready, x_rsp1_valid, x_rsp1_ready;
  logic [31:0] x_rsp0_res, x_rsp1_res;
  logic [2:0]  x_rsp0_flags, x_rsp1_flags;
  logic [31:0] x_alu_a, x_alu_b, x_alu_res;
  logic [2:0]  x_alu_ctr;
  logic        x_alu_co, x_alu_zero, x_alu_ovf, x_busy;

  assign {x_alu_ovf, x_alu_zero, x_alu_co, x_alu_res} = alu_model(x_alu_a, x_alu_b, x_alu_ctr);

  alu_arbiter #(.WIDTH(32), .CTR_W(3), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a),
    .req0_b(x_req0_b), .req0_ctr(x_req0_ctr), .rsp0_valid(x_rsp0_valid),
    .rsp0_ready(x_rsp0_ready), .rsp0_res(x_rsp0_res), .rsp0_flags(x_rsp0_flags),
    .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_a(x_req1_a),
    .req1_b(x_req1_b), .req1_ctr(x_req1_ctr), .rsp1_valid(x_rsp1_valid),
    .rsp1_ready(x_rsp1_ready), .rsp1_res(x_rsp1_res), .rsp1_flags(x_rsp1_flags),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_ctr(x_alu_ctr), .alu_res(x_alu_res),
    .alu_co(x_alu_co), .alu_zero(x_alu_zero), .alu_ovf(x_alu_ovf), .busy(x_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_ctr = 0; req1_a = 0; req1_b = 0; req1_ctr = 0;
    x_req0_valid = 0; x_req1_valid = 0; x_rsp0_ready = 0; x_rsp1_ready = 0;
    x_req0_a = 0; x_req0_b = 0; x_req0_ctr = 0; x_req1_a = 0; x_req1_b = 0; x_req1_ctr = 0;

    // ---- reset state ----
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_res", rsp0_res, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    rst_n = 1'b1;
    tick();

    // ---- single request on requester 0 ----
    req0_valid = 1; req0_a = 32'hAAAA0000; req0_b = 32'h55550000; req0_ctr = 3'd2;
    #1;
    chk("single_req0_ready", req0_ready, 1'b1);
    chk("single_req1_ready", req1_ready, 1'b0);
    tick();                               // accept edge
    req0_valid = 0;
    #1;
    chk("single_ready_pulse", req0_ready, 1'b0);
    chk("single_busy_exec", busy, 1'b1);
    chk("single_alu_a", alu_a, 32'hAAAA0000);
    chk("single_no_rsp_yet", rsp0_valid, 1'b0);
    tick();                               // capture edge
    chk("single_rsp0_valid", rsp0_valid, 1'b1);
    chk("single_res", rsp0_res, 32'hFFFF0000);
    chk("single_flags", rsp0_flags, 3'b000);
    chk("single_rsp1_valid", rsp1_valid, 1'b0);

    // ---- backpressure: rsp0_ready low for 5 cycles, req1 waiting ----
    req1_valid = 1; req1_a = 32'h1; req1_b = 32'h1; req1_ctr = 3'd2;
    rsp1_ready = 1;                       // not granted: must be ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk("bp_res", rsp0_res, 32'hFFFF0000);
      chk("bp_flags", rsp0_flags, 3'b000);
      chk("bp_busy", busy, 1'b1);
      chk("bp_req1_ready", req1_ready, 1'b0);
    end
    req1_valid = 0; rsp1_ready = 0; rsp0_ready = 1;
    tick();                               // release edge
    rsp0_ready = 0;
    #1;
    chk("bp_release_idle", busy, 1'b0);
    chk("bp_release_valid", rsp0_valid, 1'b0);

    // ---- reset mid-operation (last grant is 0 before this) ----
    req0_valid = 1; req0_a = 32'h1; req0_b = 32'h2; req0_ctr = 3'd2;
    #1;
    tick();                               // accept edge -> EXEC
    req0_valid = 0;
    chk("mid_in_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_alu_a", alu_a, 32'h0);
    chk("mid_res", rsp0_res, 32'h0);
    chk("mid_rsp0_valid", rsp0_valid, 1'b0);
    tick();
    tick();
    chk("mid_no_rsp", rsp0_valid, 1'b0);
    // Both requesters present; requester 0 must win after reset.
    req0_valid = 1; req0_a = 32'hAAAA0000; req0_b = 32'h55550000; req0_ctr = 3'd2;
    req1_valid = 1; req1_a = 32'hFFFFFFFF; req1_b = 32'h1; req1_ctr = 3'd2;
    #1;
    chk("in_rst_ready0", req0_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1'b1);
    chk("post_rst_ready1", req1_ready, 1'b0);

    // ---- contention: both continuously valid, grants alternate 0,1,0,1 ----
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 1);
      chk("cont_ready0", req0_ready, !g);
      chk("cont_ready1", req1_ready, g);
      tick();                             // accept
      tick();                             // capture
      chk("cont_rsp0_valid", rsp0_valid, !g);
      chk("cont_rsp1_valid", rsp1_valid, g);
      chk("cont_res", g ? rsp1_res : rsp0_res, g ? 32'h0 : 32'hFFFF0000);
      chk("cont_flags", g ? rsp1_flags : rsp0_flags, g ? 3'b011 : 3'b000);
      tick();                             // response consumed
      chk("cont_idle", busy, 1'b0);
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    tick();

    // ---- operand stability with EXEC_CYCLES = 4 ----
    x_req0_valid = 1; x_req0_a = 32'h7FFFFFFF; x_req0_b = 32'h1; x_req0_ctr = 3'd2;
    #1;
    chk("x_ready", x_req0_ready, 1'b1);
    tick();                               // accept edge
    x_req0_valid = 0; x_req0_a = 32'h12345678;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("x_alu_a_stable", x_alu_a, 32'h7FFFFFFF);
      chk("x_busy_exec", x_busy, 1'b1);
      chk("x_no_rsp", x_rsp0_valid, 1'b0);
      tick();
    end
    chk("x_rsp_valid", x_rsp0_valid, 1'b1);
    chk("x_res", x_rsp0_res, 32'h80000000);
    chk("x_flags", x_rsp0_flags, 3'b100);
    chk("x_rsp1_valid", x_rsp1_valid, 1'b0);
    x_rsp0_ready = 1;
    tick();
    x_rsp0_ready = 0;
    chk("x_idle", x_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
